// File: rtl/fp_mul_round_normalizer.sv
// Normalize, round and pack stage for FMUL.S: 48-bit product -> binary32 result + OF/UF/NX.
// Build macro SUBNORMAL_SUPPORT_EN: tiny results are denormalized instead of flushed to zero.
module fp_mul_round_normalizer #(
    parameter int XLEN  = 32,
    parameter int SIG_W = 24,
    parameter int EXP_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clk_en_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 sign_i,
    input  logic [EXP_W-1:0]     exponent_i,
    input  logic [2*SIG_W-1:0]   significand_i,
    input  logic                 is_nan_i,
    input  logic                 is_inf_i,
    input  logic                 is_zero_i,
    input  logic [2:0]           round_mode_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      result_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 inexact_o
);

    // state | meaning
    // IDLE  | ready_o high, waiting for a product
    // NORM  | pick 24-bit mantissa, guard and sticky; denormalize or mark tiny results
    // ROUND | apply rounding mode, detect overflow, pack result and flags
    // DONE  | valid_o high, result held until ready_i

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    localparam int IE_W = EXP_W + 2;
    localparam int P_W  = 2 * SIG_W;
`ifdef SUBNORMAL_SUPPORT_EN
    localparam bit FLUSH_TINY = 1'b0;
`else
    localparam bit FLUSH_TINY = 1'b1;
`endif

    state_t           state_q;
    logic             ready_q, valid_q, of_q, uf_q, nx_q;
    logic             sign_q, nan_q, inf_q, zero_q, tiny_q, g_q, s_q;
    logic [2:0]       rm_q;
    logic [IE_W-1:0]  exp_q;
    logic [P_W-1:0]   sig_q;
    logic [SIG_W-1:0] mant_q;
    logic [XLEN-1:0]  result_q;

    logic [IE_W-1:0]  norm_exp_d;
    logic [SIG_W-1:0] norm_mant_d;
    logic             norm_g_d, norm_s_d, norm_tiny_d;
`ifdef SUBNORMAL_SUPPORT_EN
    logic [IE_W-1:0]  shift_full;
    logic [4:0]       shift_amt;
    logic [P_W-1:0]   shifted;
`endif

    always_comb begin
        if (sig_q[P_W-1]) begin
            norm_mant_d = sig_q[P_W-1 -: SIG_W];
            norm_g_d    = sig_q[SIG_W-1];
            norm_s_d    = |sig_q[SIG_W-2:0];
            norm_exp_d  = exp_q + IE_W'(1);
        end else begin
            norm_mant_d = sig_q[P_W-2 -: SIG_W];
            norm_g_d    = sig_q[SIG_W-2];
            norm_s_d    = |sig_q[SIG_W-3:0];
            norm_exp_d  = exp_q;
        end
        norm_tiny_d = norm_exp_d[IE_W-1] | (norm_exp_d == '0);
`ifdef SUBNORMAL_SUPPORT_EN
        // Beyond 25 places every mantissa bit lands in sticky, so the shift saturates there.
        shift_full = IE_W'(1) - norm_exp_d;
        shift_amt  = (shift_full > IE_W'(25)) ? 5'd25 : shift_full[4:0];
        shifted    = {norm_mant_d, {SIG_W{1'b0}}} >> shift_amt;
        if (norm_tiny_d) begin
            norm_s_d    = norm_g_d | norm_s_d | (|shifted[SIG_W-2:0]);
            norm_g_d    = shifted[SIG_W-1];
            norm_mant_d = shifted[P_W-1 -: SIG_W];
            norm_exp_d  = '0;
        end
`endif
    end

    logic             inc, rnd_nx, rnd_ovf, max_finite;
    logic [SIG_W:0]   mant_sum;
    logic [SIG_W-1:0] rnd_mant;
    logic [IE_W-1:0]  rnd_exp;
    logic [XLEN-1:0]  res_d;
    logic             of_d, uf_d, nx_d;

    always_comb begin
        case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q & (g_q | s_q);
            3'b011:  inc = ~sign_q & (g_q | s_q);
            3'b100:  inc = g_q;
            default: inc = g_q & (s_q | mant_q[0]);
        endcase
        mant_sum = {1'b0, mant_q} + {{SIG_W{1'b0}}, inc};
        if (mant_sum[SIG_W]) begin
            rnd_mant = {1'b1, {(SIG_W-1){1'b0}}};
            rnd_exp  = exp_q + IE_W'(1);
        end else begin
            rnd_mant = mant_sum[SIG_W-1:0];
            rnd_exp  = exp_q;
        end
        // A denormal that rounds up into the hidden bit becomes the smallest normal.
        if (tiny_q && rnd_mant[SIG_W-1]) rnd_exp = IE_W'(1);
        rnd_nx     = g_q | s_q;
        rnd_ovf    = ~rnd_exp[IE_W-1] & (rnd_exp >= IE_W'(255));
        max_finite = (rm_q == 3'b001) | ((rm_q == 3'b010) & ~sign_q)
                   | ((rm_q == 3'b011) & sign_q);

        res_d = {sign_q, rnd_exp[7:0], rnd_mant[SIG_W-2:0]};
        of_d  = 1'b0;
        nx_d  = rnd_nx;
        uf_d  = tiny_q & rnd_nx;
        if (nan_q) begin
            res_d = 32'h7FC0_0000;
            nx_d  = 1'b0;
            uf_d  = 1'b0;
        end else if (inf_q) begin
            res_d = {sign_q, 31'h7F80_0000};
            nx_d  = 1'b0;
            uf_d  = 1'b0;
        end else if (zero_q) begin
            res_d = {sign_q, 31'h0};
            nx_d  = 1'b0;
            uf_d  = 1'b0;
        end else if (tiny_q && FLUSH_TINY) begin
            res_d = {sign_q, 31'h0};
            nx_d  = (|mant_q) | rnd_nx;
            uf_d  = nx_d;
        end else if (rnd_ovf) begin
            res_d = max_finite ? {sign_q, 31'h7F7F_FFFF} : {sign_q, 31'h7F80_0000};
            of_d  = 1'b1;
            uf_d  = 1'b0;
            nx_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            of_q     <= 1'b0;
            uf_q     <= 1'b0;
            nx_q     <= 1'b0;
            sign_q   <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            tiny_q   <= 1'b0;
            g_q      <= 1'b0;
            s_q      <= 1'b0;
            rm_q     <= '0;
            exp_q    <= '0;
            sig_q    <= '0;
            mant_q   <= '0;
        end else if (clk_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i && ready_q) begin
                        sign_q  <= sign_i;
                        exp_q   <= {{(IE_W-EXP_W){exponent_i[EXP_W-1]}}, exponent_i};
                        sig_q   <= significand_i;
                        nan_q   <= is_nan_i;
                        inf_q   <= is_inf_i;
                        zero_q  <= is_zero_i;
                        rm_q    <= round_mode_i;
                        ready_q <= 1'b0;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    mant_q  <= norm_mant_d;
                    g_q     <= norm_g_d;
                    s_q     <= norm_s_d;
                    exp_q   <= norm_exp_d;
                    tiny_q  <= norm_tiny_d;
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    result_q <= res_d;
                    of_q     <= of_d;
                    uf_q     <= uf_d;
                    nx_q     <= nx_d;
                    valid_q  <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign valid_o     = valid_q;
    assign result_o    = result_q;
    assign overflow_o  = of_q;
    assign underflow_o = uf_q;
    assign inexact_o   = nx_q;

endmodule

// File: tb/tb_fp_mul_round_normalizer.sv
// Self-checking bench for fp_mul_round_normalizer: directed vector table, handshake/reset
// sequences, and random operands with random clk_en against an arithmetic reference model.
module tb_fp_mul_round_normalizer;

`ifdef SUBNORMAL_SUPPORT_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1;
    logic        valid_i = 1'b0, ready_i = 1'b0;
    logic        sign = 1'b0, nan = 1'b0, inf = 1'b0, zero = 1'b0;
    logic [9:0]  expo = '0;
    logic [47:0] sig = '0;
    logic [2:0]  rm = '0;
    logic        ready_o, valid_o, of, uf, nx;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    bit en_rand = 1'b0;

    fp_mul_round_normalizer dut (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en),
        .valid_i(valid_i), .ready_o(ready_o),
        .sign_i(sign), .exponent_i(expo), .significand_i(sig),
        .is_nan_i(nan), .is_inf_i(inf), .is_zero_i(zero),
        .round_mode_i(rm),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result),
        .overflow_o(of), .underflow_o(uf), .inexact_o(nx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (en_rand) clk_en = ($urandom % 2) == 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        sg;
        logic [9:0]  ex;
        logic [47:0] sv;
        logic [2:0]  spc;   // {nan, inf, zero}
        logic [2:0]  rm;
        logic [31:0] res;
        logic [2:0]  fl;    // {of, uf, nx}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic sg, logic [9:0] ex, logic [47:0] sv,
                                logic [2:0] spc, logic [2:0] m, logic [31:0] r, logic [2:0] f);
        vec_t v;
        v.name = nm; v.sg = sg; v.ex = ex; v.sv = sv; v.spc = spc; v.rm = m; v.res = r; v.fl = f;
        return v;
    endfunction

    // Value-level model: keep sig / 2^n, the remainder decides guard and sticky.
    function automatic logic [34:0] model(logic sg, int e_in, longint unsigned sv,
                                          logic [2:0] spc, logic [2:0] m);
        longint unsigned mant, rem, half, q;
        int  n, e;
        bit  g, s, tiny, up;
        if (spc[2]) return {32'h7FC00000, 3'b000};
        if (spc[1]) return {sg, 31'h7F800000, 3'b000};
        if (spc[0]) return {sg, 31'h0, 3'b000};
        e = e_in;
        n = 23;
        if (sv >= (64'd1 << 47)) begin n = 24; e = e + 1; end
        tiny = (e <= 0);
        if (tiny && !SUB) return {sg, 31'h0, 1'b0, 1'b1, sv != 0};
        if (tiny) n = n + (((1 - e) > 25) ? 25 : (1 - e));
        mant = sv >> n;
        rem  = sv - (mant << n);
        half = 64'd1 << (n - 1);
        g = rem >= half;
        s = (rem % half) != 0;
        case (m)
            3'd1:    up = 1'b0;
            3'd2:    up = sg && (g || s);
            3'd3:    up = !sg && (g || s);
            3'd4:    up = g;
            default: up = g && (s || mant[0]);
        endcase
        q = mant + 64'(up);
        if (tiny) e = (q >= 64'd8388608) ? 1 : 0;
        else if (q == 64'd16777216) begin q = 64'd8388608; e = e + 1; end
        if (!tiny && e >= 255) begin
            if (m == 3'd1 || (m == 3'd2 && !sg) || (m == 3'd3 && sg))
                return {sg, 31'h7F7FFFFF, 3'b101};
            return {sg, 31'h7F800000, 3'b101};
        end
        return {sg, 8'(e), 23'(q), 1'b0, tiny && (g || s), g || s};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic do_op(input logic sg, input logic [9:0] ex, input logic [47:0] sv,
                         input logic [2:0] spc, input logic [2:0] m, output logic [34:0] got);
        int n;
        got = '0;
        n = 0;
        while (!ready_o && n < 100) begin @(negedge clk); n++; end
        sign = sg; expo = ex; sig = sv; {nan, inf, zero} = spc; rm = m;
        valid_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (ready_o && n < 100);
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 100) begin @(negedge clk); n++; end
        if (!valid_o) check("op_timeout_valid", 64'(valid_o), 64'd1);
        got = {result, of, uf, nx};
        ready_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (valid_o && n < 100);
        ready_i = 1'b0;
    endtask

    initial begin
        logic [34:0] got;
        logic [63:0] r64;
        logic [47:0] sv;
        logic [9:0]  ex;
        logic [2:0]  spc, m;
        logic        sg;
        int          lat, r;

        vecs.push_back(mk("mul15",        0, 10'd127, 48'h900000000000, 3'b000, 3'd0, 32'h40100000, 3'b000));
        vecs.push_back(mk("mul15_neg",    1, 10'd127, 48'h900000000000, 3'b000, 3'd0, 32'hC0100000, 3'b000));
        vecs.push_back(mk("tie_rne",      0, 10'd127, 48'h400000400000, 3'b000, 3'd0, 32'h3F800000, 3'b001));
        vecs.push_back(mk("tie_rup",      0, 10'd127, 48'h400000400000, 3'b000, 3'd3, 32'h3F800001, 3'b001));
        vecs.push_back(mk("tie_rmm",      0, 10'd127, 48'h400000400000, 3'b000, 3'd4, 32'h3F800001, 3'b001));
        vecs.push_back(mk("tie_rm7",      0, 10'd127, 48'h400000400000, 3'b000, 3'd7, 32'h3F800000, 3'b001));
        vecs.push_back(mk("tie_rdn_neg",  1, 10'd127, 48'h400000400000, 3'b000, 3'd2, 32'hBF800001, 3'b001));
        vecs.push_back(mk("carry_rne",    0, 10'd127, 48'hFFFFFF800000, 3'b000, 3'd0, 32'h40800000, 3'b001));
        vecs.push_back(mk("carry_rtz",    0, 10'd127, 48'hFFFFFF800000, 3'b000, 3'd1, 32'h407FFFFF, 3'b001));
        vecs.push_back(mk("ovf_rne",      0, 10'd254, 48'h800000000000, 3'b000, 3'd0, 32'h7F800000, 3'b101));
        vecs.push_back(mk("ovf_rtz",      0, 10'd254, 48'h800000000000, 3'b000, 3'd1, 32'h7F7FFFFF, 3'b101));
        vecs.push_back(mk("ovf_rdn_pos",  0, 10'd254, 48'h800000000000, 3'b000, 3'd2, 32'h7F7FFFFF, 3'b101));
        vecs.push_back(mk("ovf_rdn_neg",  1, 10'd254, 48'h800000000000, 3'b000, 3'd2, 32'hFF800000, 3'b101));
        vecs.push_back(mk("ovf_rup_neg",  1, 10'd254, 48'h800000000000, 3'b000, 3'd3, 32'hFF7FFFFF, 3'b101));
        vecs.push_back(mk("ovf_rmm",      0, 10'd254, 48'h800000000000, 3'b000, 3'd4, 32'h7F800000, 3'b101));
        vecs.push_back(mk("max_exp",      0, 10'd254, 48'h400000000000, 3'b000, 3'd0, 32'h7F000000, 3'b000));
        vecs.push_back(mk("ovf_round",    0, 10'd253, 48'hFFFFFF800000, 3'b000, 3'd0, 32'h7F800000, 3'b101));
        vecs.push_back(mk("ovf_rnd_rtz",  0, 10'd253, 48'hFFFFFF800000, 3'b000, 3'd1, 32'h7F7FFFFF, 3'b001));
        vecs.push_back(mk("min_norm",     0, 10'd1,   48'h400000000000, 3'b000, 3'd0, 32'h00800000, 3'b000));
        vecs.push_back(mk("tiny_exact",   0, 10'd0,   48'h400000000000, 3'b000, 3'd0,
                          SUB ? 32'h00400000 : 32'h00000000, SUB ? 3'b000 : 3'b011));
        vecs.push_back(mk("tiny_neg",     1, 10'h3FF, 48'h800000000000, 3'b000, 3'd0,
                          SUB ? 32'h80400000 : 32'h80000000, SUB ? 3'b000 : 3'b011));
        vecs.push_back(mk("tiny_to_norm", 0, 10'd0,   48'h7FFFFF800000, 3'b000, 3'd0,
                          SUB ? 32'h00800000 : 32'h00000000, 3'b011));
        vecs.push_back(mk("tiny_rtz",     0, 10'd0,   48'h7FFFFF800000, 3'b000, 3'd1,
                          SUB ? 32'h007FFFFF : 32'h00000000, 3'b011));
        vecs.push_back(mk("tiny_deep",    0, 10'h338, 48'h400000000000, 3'b000, 3'd3,
                          SUB ? 32'h00000001 : 32'h00000000, 3'b011));
        vecs.push_back(mk("nan",          0, 10'd0,   48'h0,            3'b100, 3'd0, 32'h7FC00000, 3'b000));
        vecs.push_back(mk("nan_inf",      1, 10'd5,   48'h900000000000, 3'b110, 3'd0, 32'h7FC00000, 3'b000));
        vecs.push_back(mk("inf_neg",      1, 10'd0,   48'h0,            3'b010, 3'd0, 32'hFF800000, 3'b000));
        vecs.push_back(mk("inf_zero",     0, 10'd0,   48'h0,            3'b011, 3'd0, 32'h7F800000, 3'b000));
        vecs.push_back(mk("zero_neg",     1, 10'd0,   48'h0,            3'b001, 3'd1, 32'h80000000, 3'b000));

        repeat (3) @(negedge clk);
        check("reset_state", {ready_o, valid_o, result, of, uf, nx}, {1'b1, 1'b0, 32'h0, 3'b000});
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].sg, vecs[i].ex, vecs[i].sv, vecs[i].spc, vecs[i].rm, got);
            check(vecs[i].name, 64'(got), 64'({vecs[i].res, vecs[i].fl}));
        end

        // Latency: valid_o rises on the third enabled edge counting the accept edge.
        @(negedge clk);
        sign = 0; expo = 10'd127; sig = 48'h900000000000; {nan, inf, zero} = 3'b000; rm = 3'd0;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        check("accept_ready_drop", 64'(ready_o), 64'd0);
        lat = 1;
        while (!valid_o && lat < 20) begin @(negedge clk); lat++; end
        check("latency", 64'(lat), 64'd3);
        check("latency_result", 64'({result, of, uf, nx}), 64'({32'h40100000, 3'b000}));
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("release_ready", 64'({valid_o, ready_o}), 64'(2'b01));

        // Hold in DONE with ready_i low while extra valid_i is presented.
        sign = 0; sig = 48'h0; {nan, inf, zero} = 3'b100;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 20) begin @(negedge clk); lat++; end
        sign = 1; expo = 10'd127; sig = 48'h900000000000; {nan, inf, zero} = 3'b000;
        valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d", k), 64'({valid_o, ready_o, result, of, uf, nx}),
                  64'({1'b1, 1'b0, 32'h7FC00000, 3'b000}));
        end
        ready_i = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        ready_i = 1'b0;
        check("hold_release", 64'({valid_o, ready_o}), 64'(2'b01));
        repeat (4) @(negedge clk);
        check("no_queue", 64'({valid_o, ready_o}), 64'(2'b01));

        // clk_en low in DONE freezes valid_o/result and ignores ready_i.
        sign = 0; expo = 10'd127; sig = 48'h400000400000; {nan, inf, zero} = 3'b000; rm = 3'd3;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 20) begin @(negedge clk); lat++; end
        clk_en = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("en_low_done", 64'({valid_o, ready_o, result, of, uf, nx}),
              64'({1'b1, 1'b0, 32'h3F800001, 3'b001}));
        clk_en = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("en_high_release", 64'({valid_o, ready_o}), 64'(2'b01));

        // Reset while in ROUND aborts with no result.
        sign = 0; expo = 10'd127; sig = 48'h900000000000; rm = 3'd0;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_abort", 64'({valid_o, ready_o, result, of, uf, nx}),
              64'({1'b0, 1'b1, 32'h0, 3'b000}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_no_result", 64'({valid_o, ready_o}), 64'(2'b01));

        en_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r64 = {$urandom, $urandom};
            sv  = r64[47:0];
            if (!sv[47]) sv[46] = 1'b1;
            ex  = 10'(int'($urandom_range(0, 320)) - 40);
            sg  = 1'($urandom % 2);
            m   = 3'($urandom_range(0, 7));
            r   = int'($urandom_range(0, 31));
            spc = (r == 0) ? 3'b100 : (r == 1) ? 3'b010 : (r == 2) ? 3'b001 : 3'b000;
            do_op(sg, ex, sv, spc, m, got);
            check($sformatf("rand%0d sg=%0d ex=%0h sig=%0h rm=%0d spc=%0b", i, sg, ex, sv, m, spc),
                  64'(got), 64'(model(sg, int'($signed(ex)), 64'(sv), spc, m)));
        end
        en_rand = 1'b0;
        clk_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
